// File: rtl/weight_stream_reader.sv
// weight_stream_reader: streams DEPTH weights from a BRAM in address order; START/BUSY/DONE control, BRAM_ADDR/EN/WE/DO read port, W_DATA/VALID/READY/LAST/INDEX beat stream
module weight_stream_reader #(
  parameter int DEPTH  = 28,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  output logic              BRAM_EN,
  output logic              BRAM_WE,
  input  logic [DATA_W-1:0] BRAM_DO,
  output logic [DATA_W-1:0] W_DATA,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic              W_LAST,
  output logic [ADDR_W-1:0] W_INDEX
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  state_t state;
  logic [DATA_W-1:0] buf_data [2];
  logic [ADDR_W-1:0] buf_idx [2];
  logic [1:0] buf_last;
  logic [1:0] occ;
  logic rd, wr, pop, room, last_issue;
  assign pop        = W_VALID & W_READY;
  assign room       = ({1'b0, occ} + {2'b0, BRAM_EN}) < (3'd2 + {2'b0, pop});
  assign last_issue = BRAM_EN && BRAM_ADDR == LAST_ADDR;
  assign W_VALID    = occ != 2'd0;
  assign W_DATA     = buf_data[rd];
  assign W_INDEX    = buf_idx[rd];
  assign W_LAST     = W_VALID & buf_last[rd];
  assign BUSY       = state != IDLE;
  assign BRAM_WE    = 1'b0;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      DONE      <= 1'b0;
      BRAM_EN   <= 1'b0;
      BRAM_ADDR <= '0;
      buf_data  <= '{default: '0};
      buf_idx   <= '{default: '0};
      buf_last  <= '0;
      occ       <= '0;
      rd        <= 1'b0;
      wr        <= 1'b0;
    end else begin
      DONE <= 1'b0;
      // every issue cycle lands its word at the edge that ends it
      if (BRAM_EN) begin
        buf_data[wr] <= BRAM_DO;
        buf_idx[wr]  <= BRAM_ADDR;
        buf_last[wr] <= BRAM_ADDR == LAST_ADDR;
        wr           <= ~wr;
      end
      if (pop) rd <= ~rd;
      occ <= occ + {1'b0, BRAM_EN} - {1'b0, pop};
      case (state)
        IDLE: begin
          BRAM_EN <= START;
          if (START) begin
            state     <= FETCH;
            BRAM_ADDR <= '0;
          end
        end
        FETCH: begin
          // BRAM_ADDR holds the last issued address, so the next one is +1
          BRAM_EN <= !last_issue && room;
          if (last_issue) state <= DRAIN;
          else if (room) BRAM_ADDR <= BRAM_ADDR + ADDR_W'(1);
        end
        DRAIN: begin
          BRAM_EN <= 1'b0;
          if (pop && W_LAST) begin
            state <= IDLE;
            DONE  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/weight_stream_reader.md
# weight_stream_reader

Read-side sequencer for a single-port weight BRAM (16-bit words, 5-bit address, read data updated on the falling edge of `CLK`). On `START` it fetches the `DEPTH` weights of one neuron in address order. It streams them to the neuron MAC over a valid/ready interface with full backpressure support, then pulses `DONE`. It is the initiator that drives the BRAM's `ADDR`/`EN`/`WE` pins, one instance per weight BRAM.

## Interface
- `DEPTH`, 28, number of weights per neuron; addresses `0..DEPTH-1`.
- `ADDR_W`, 5, BRAM address width; requires `DEPTH <= 2**ADDR_W`.
- `DATA_W`, 16, weight word width.

Ports:
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `START` input 1: one-cycle request to stream all weights; ignored while `BUSY`.
- `BUSY` output 1: high from the edge that accepts `START` until the edge of the final handshake.
- `DONE` output 1: one-cycle pulse on the cycle after the final handshake.
- `BRAM_ADDR` output `ADDR_W`: BRAM address (registered).
- `BRAM_EN` output 1: BRAM enable (registered); high only in cycles that issue a read.
- `BRAM_WE` output 1: constant 0.
- `BRAM_DO` input `DATA_W`: BRAM read data, valid at the rising edge following an issue cycle.
- `W_DATA` output `DATA_W`: weight beat.
- `W_VALID` output 1: beat valid.
- `W_READY` input 1: consumer ready; a handshake is `W_VALID & W_READY` at a rising edge.
- `W_LAST` output 1: high with the beat from address `DEPTH-1`.
- `W_INDEX` output `ADDR_W`: address the current beat came from.

## Operation
- FSM states:
  - IDLE: `START=1` → FETCH, with issue pointer set to 0.
  - FETCH: issues reads. After the read of address `DEPTH-1` is issued → DRAIN.
  - DRAIN: waits for the final handshake → IDLE, with `DONE` pulsed for one cycle.
- Read issue rule: in FETCH, issue (`BRAM_EN=1`, `BRAM_ADDR=ptr`) in the next cycle iff `occ + inflight - pop < 2`.
  - `occ` is the output buffer count (0..2).
  - `inflight` is 1 if a read was issued this cycle.
  - `pop` is the handshake this cycle.
  - `ptr` increments per issue; no wrap. The pointer stops at `DEPTH-1`.
- Output buffer: 2-entry FIFO. The push is `BRAM_DO` at the edge ending an issue cycle, tagged with its address and the last flag. The head drives `W_DATA`/`W_INDEX`/`W_LAST`, and `W_VALID = (occ != 0)`.
- Simultaneous push and pop: both take effect and `occ` is unchanged. The buffer never overflows, because the issue rule guarantees this.
- `W_DATA`, `W_INDEX` and `W_LAST` hold stable while `W_VALID=1` and `W_READY=0`.
- `START` during FETCH or DRAIN is ignored and not queued. `START` in the same cycle as `DONE` is accepted, since the FSM is in IDLE.
- Reset (any time, including mid-stream): state goes to IDLE, the pointer and buffer are cleared, and no partial stream resumes. Reset values:
  - `BUSY=0`, `DONE=0`
  - `BRAM_EN=0`, `BRAM_ADDR=0`, `BRAM_WE=0`
  - `W_VALID=0`, `W_DATA=0`, `W_INDEX=0`, `W_LAST=0`

## Timing
- Edge numbering: `START` is sampled at edge E0.
  - Cycle E0–E1: `BUSY=1`, `BRAM_EN=1`, `BRAM_ADDR=0`.
  - E1: the BRAM word is captured.
  - From E1: `W_VALID=1`, `W_DATA=mem[0]`.
- With `W_READY` held high:
  - One read per cycle.
  - Beat k is valid after E(k+1) and handshakes at E(k+2).
  - The last handshake is at E(DEPTH+1), i.e. E29 for the default.
  - After E29: `DONE=1` and `BUSY=0` for exactly one cycle, then `DONE=0`.
- `W_READY` low: the buffer fills to 2 and issue stops. When ready returns, beats resume back-to-back without gaps and without loss or duplication.
- Minimum `START` to `DONE` is `DEPTH+2` edges.

## Test plan
- Nominal stream: BRAM loaded with `mem[i]=16'h0100+i`, pulse `START`, `W_READY=1` → 28 consecutive beats `0x0100..0x011B`.
  - `W_INDEX` is 0..27.
  - `W_LAST` is high only on beat 27.
  - `DONE` is high exactly one cycle, 30 edges after `START`.
- Backpressure: `W_READY` toggles 1,0,0,1 repeating, plus a 10-cycle stall at beat 5 → identical data sequence, no duplicates.
  - Outputs stay stable during every stall.
  - `BRAM_EN` cycles never exceed accepted beats by more than 2.
- Ignored start: extra `START` pulses at beats 3 and 27 → exactly 28 beats and one `DONE`.
  - A `START` coincident with `DONE` launches a second full 28-beat stream.
- Reset mid-stream: assert `RST` during beat 12 → all outputs are 0 immediately (asynchronous).
  - After release with no `START`: `W_VALID` stays 0 for 50 cycles.
  - After a new `START`: the stream begins at index 0.
- BRAM interface check: over a full run with random `W_READY` → `BRAM_WE` is always 0.
  - `BRAM_EN` is asserted exactly 28 times.
  - Addresses are issued strictly increasing 0..27.
